// File: rtl/enum_chan_sequencer_pkg.sv
// Shared types and next-state logic for the multi-channel phase sequencer.
package seq_pkg;

    localparam int SEQ_STATE_W = 3;

    // Codes are fixed and Gray-adjacent along IDLE->ARM->RUN->DRAIN->DONE.
    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE  = 3'b000,
        ST_ARM   = 3'b001,
        ST_RUN   = 3'b011,
        ST_DRAIN = 3'b010,
        ST_DONE  = 3'b110
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_LOOP    = 2'b01,
        MODE_STEP    = 2'b10
    } seq_mode_e;

    // The unused mode code 2'b11 behaves as one-shot.
    function automatic seq_mode_e seq_decode_mode(input logic [1:0] mode);
        case (mode)
            2'b01:   return MODE_LOOP;
            2'b10:   return MODE_STEP;
            default: return MODE_ONESHOT;
        endcase
    endfunction

    // A RUN cycle counts unless the channel is single-stepping without a step.
    function automatic logic seq_step_enabled(input logic [1:0] mode, input logic step);
        return (seq_decode_mode(mode) != MODE_STEP) || step;
    endfunction

    // Abort wins over every other transition, including a start in IDLE.
    function automatic seq_state_e seq_next(
        input seq_state_e st,
        input logic [1:0] mode,
        input logic       start,
        input logic       abort,
        input logic       step,
        input logic       ready,
        input logic       len_zero,
        input logic       cnt_one
    );
        if (abort) return ST_IDLE;
        case (st)
            ST_IDLE:  return start ? ST_ARM : ST_IDLE;
            ST_ARM:   return len_zero ? ST_DONE : ST_RUN;
            ST_RUN:   return (seq_step_enabled(mode, step) && cnt_one) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: return ST_DONE;
            ST_DONE: begin
                if (!ready) return ST_DONE;
                return (seq_decode_mode(mode) == MODE_LOOP) ? ST_ARM : ST_IDLE;
            end
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/enum_chan_sequencer_if.sv
// Control/status bundle between the sequencer and its user.
interface enum_chan_sequencer_if #(
    parameter int NCH   = 4,
    parameter int LEN_W = 8
);
    localparam int BUSY_W = $clog2(NCH + 1);

    logic [1:0]           mode_i;
    logic [NCH-1:0]       start_i;
    logic [NCH-1:0]       abort_i;
    logic [NCH-1:0]       step_i;
    logic [NCH*LEN_W-1:0] len_i;
    logic [NCH-1:0]       ready_i;
    logic [NCH*3-1:0]     state_o;
    logic [NCH-1:0]       done_o;
    logic [BUSY_W-1:0]    busy_cnt_o;

    modport master (
        output mode_i, start_i, abort_i, step_i, len_i, ready_i,
        input  state_o, done_o, busy_cnt_o
    );

    modport slave (
        input  mode_i, start_i, abort_i, step_i, len_i, ready_i,
        output state_o, done_o, busy_cnt_o
    );
endinterface

// File: rtl/enum_chan_sequencer_chan.sv
// One sequencer channel: phase FSM plus run-length down-counter.
module enum_seq_chan
    import seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       i_mode,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_step,
    input  logic             i_ready,
    input  logic [LEN_W-1:0] i_len,
    output seq_state_e       o_state,
    output logic             o_done,
    output seq_state_e       o_nxt_state
);

    seq_state_e       r_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_done;
    seq_state_e       w_nxt_state;
    logic             w_en;

    assign w_en        = seq_step_enabled(i_mode, i_step);
    assign w_nxt_state = seq_next(r_state, i_mode, i_start, i_abort, i_step, i_ready,
                                  (i_len == '0), (r_cnt == LEN_W'(1)));

    // State, counter and registered done flag advance together each cycle.
    // NOTE: all sequential state uses non-blocking assignments and is cleared by the async reset so a mid-run reset drops every channel straight back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_done  <= (w_nxt_state == ST_DONE);
            if (i_abort)
                r_cnt <= '0;
            else if (r_state == ST_ARM)
                r_cnt <= i_len;
            else if (r_state == ST_RUN && w_en)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_state     = r_state;
    assign o_done      = r_done;
    assign o_nxt_state = w_nxt_state;

endmodule

// File: rtl/enum_chan_sequencer.sv
// NCH independent phase sequencers plus a registered busy-channel count.
module enum_chan_sequencer
    import seq_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int LEN_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    enum_chan_sequencer_if.slave   bus
);

    localparam int BUSY_W = $clog2(NCH + 1);

    seq_pkg::seq_state_e     w_chan_state [NCH];
    seq_state_e              w_nxt_state  [NCH];
    logic [NCH-1:0]          w_done;
    logic [NCH*SEQ_STATE_W-1:0] w_state_flat;
    logic [BUSY_W-1:0]       w_busy_sum;
    logic [BUSY_W-1:0]       r_busy_cnt;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        enum_seq_chan #(.LEN_W(LEN_W)) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_mode      (bus.mode_i),
            .i_start     (bus.start_i[c]),
            .i_abort     (bus.abort_i[c]),
            .i_step      (bus.step_i[c]),
            .i_ready     (bus.ready_i[c]),
            .i_len       (bus.len_i[c*LEN_W +: LEN_W]),
            .o_state     (w_chan_state[c]),
            .o_done      (w_done[c]),
            .o_nxt_state (w_nxt_state[c])
        );
    end

    // Pack per-channel state codes into the exported debug bus.
    always_comb begin
        w_state_flat = '0;
        for (int c = 0; c < NCH; c++)
            w_state_flat[c*SEQ_STATE_W +: SEQ_STATE_W] = w_chan_state[c];
    end

    // Count channels that will be non-idle after this edge.
    always_comb begin
        w_busy_sum = '0;
        for (int c = 0; c < NCH; c++)
            if (w_nxt_state[c] != ST_IDLE)
                w_busy_sum = w_busy_sum + BUSY_W'(1);
    end

    // Register the count so it lines up with the registered state codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy_cnt <= '0;
        else
            r_busy_cnt <= w_busy_sum;
    end

    assign bus.state_o    = w_state_flat;
    assign bus.done_o     = w_done;
    assign bus.busy_cnt_o = r_busy_cnt;

endmodule

// File: tb/tb_enum_chan_sequencer.sv
// Directed, table-driven bench for enum_chan_sequencer (NCH=4, LEN_W=8).
module tb_enum_chan_sequencer;

    localparam int NCH   = 4;
    localparam int LEN_W = 8;

    // State codes written out independently of the design package.
    localparam logic [2:0] I = 3'b000;
    localparam logic [2:0] A = 3'b001;
    localparam logic [2:0] R = 3'b011;
    localparam logic [2:0] D = 3'b010;
    localparam logic [2:0] O = 3'b110;

    typedef struct packed {
        logic [1:0]  mode;
        logic [3:0]  start;
        logic [3:0]  abort;
        logic [3:0]  step;
        logic [3:0]  ready;
        logic [31:0] len;
        logic [11:0] exp_state;
        logic [3:0]  exp_done;
        logic [2:0]  exp_busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl[$];

    enum_chan_sequencer_if #(.NCH(NCH), .LEN_W(LEN_W)) bus ();

    enum_chan_sequencer #(.NCH(NCH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] st4(logic [2:0] s3, logic [2:0] s2, logic [2:0] s1, logic [2:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [31:0] lens(logic [7:0] l3, logic [7:0] l2, logic [7:0] l1, logic [7:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mk(logic [1:0] mode, logic [3:0] start, logic [3:0] abort,
                                logic [3:0] step, logic [3:0] ready, logic [31:0] len,
                                logic [11:0] st, logic [3:0] dn, logic [2:0] busy);
        vec_t v;
        v.mode = mode; v.start = start; v.abort = abort; v.step = step; v.ready = ready;
        v.len = len; v.exp_state = st; v.exp_done = dn; v.exp_busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [11:0] st, input logic [3:0] dn, input logic [2:0] busy);
        check({tag, ".state"}, 32'(bus.state_o), 32'(st));
        check({tag, ".done"},  32'(bus.done_o),  32'(dn));
        check({tag, ".busy"},  32'(bus.busy_cnt_o), 32'(busy));
    endtask

    task automatic drive(input logic [1:0] mode, input logic [3:0] start, input logic [3:0] abort,
                         input logic [3:0] step, input logic [3:0] ready, input logic [31:0] len);
        bus.mode_i  = mode;
        bus.start_i = start;
        bus.abort_i = abort;
        bus.step_i  = step;
        bus.ready_i = ready;
        bus.len_i   = len;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input string tag, input vec_t v);
        drive(v.mode, v.start, v.abort, v.step, v.ready, v.len);
        tick();
        check_outs(tag, v.exp_state, v.exp_done, v.exp_busy);
    endtask

    initial begin
        // One-shot, ch0 len 3: ARM@1, RUN@2-4, DRAIN@5, DONE@6 held until ready@10.
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0, lens(0,0,0,3), st4(I,I,I,A), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,0,3), st4(I,I,I,R), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,0,3), st4(I,I,I,R), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,0,3), st4(I,I,I,R), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,0,3), st4(I,I,I,D), 4'b0000, 3'd1));
        for (int k = 5; k < 10; k++)
            tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,0,3), st4(I,I,I,O), 4'b0001, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0001, lens(0,0,0,3), st4(I,I,I,I), 4'b0000, 3'd0));
        // Zero length on ch1 with mode 2'b11 (one-shot): ARM then DONE, then IDLE.
        tbl.push_back(mk(2'd3, 4'b0010, 4'b0, 4'b0, 4'b0, lens(0,0,0,0), st4(I,I,A,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd3, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,0,0), st4(I,I,O,I), 4'b0010, 3'd1));
        tbl.push_back(mk(2'd3, 4'b0000, 4'b0, 4'b0, 4'b0010, lens(0,0,0,0), st4(I,I,I,I), 4'b0000, 3'd0));
        // Abort together with start in IDLE: stays IDLE.
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0001, 4'b0, 4'b0, lens(0,0,5,5), st4(I,I,I,I), 4'b0000, 3'd0));
        // Two channels running, abort ch0 mid-RUN, then ch1.
        tbl.push_back(mk(2'd0, 4'b0011, 4'b0, 4'b0, 4'b0, lens(0,0,5,5), st4(I,I,A,A), 4'b0000, 3'd2));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,5,5), st4(I,I,R,R), 4'b0000, 3'd2));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,5,5), st4(I,I,R,R), 4'b0000, 3'd2));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0001, 4'b0, 4'b0, lens(0,0,5,5), st4(I,I,R,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(0,0,5,5), st4(I,I,R,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0010, 4'b0, 4'b0, lens(0,0,5,5), st4(I,I,I,I), 4'b0000, 3'd0));
        // Held start on ch0, len 1: completes, then restarts from IDLE.
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0, lens(0,0,0,1), st4(I,I,I,A), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0, lens(0,0,0,1), st4(I,I,I,R), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0, lens(0,0,0,1), st4(I,I,I,D), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0, lens(0,0,0,1), st4(I,I,I,O), 4'b0001, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0001, lens(0,0,0,1), st4(I,I,I,I), 4'b0000, 3'd0));
        tbl.push_back(mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0, lens(0,0,0,1), st4(I,I,I,A), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0001, 4'b0, 4'b0, lens(0,0,0,1), st4(I,I,I,I), 4'b0000, 3'd0));
        // Loop on ch2, ready tied high: len 2 run, len changed to 4 mid-RUN takes effect on next ARM.
        tbl.push_back(mk(2'd1, 4'b0100, 4'b0, 4'b0, 4'b0100, lens(0,2,0,0), st4(I,A,I,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,2,0,0), st4(I,R,I,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,R,I,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,D,I,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,O,I,I), 4'b0100, 3'd1));
        tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,A,I,I), 4'b0000, 3'd1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,R,I,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,D,I,I), 4'b0000, 3'd1));
        tbl.push_back(mk(2'd1, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,O,I,I), 4'b0100, 3'd1));
        tbl.push_back(mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0100, lens(0,4,0,0), st4(I,I,I,I), 4'b0000, 3'd0));

        // Reset state.
        drive(2'd0, 4'b0, 4'b0, 4'b0, 4'b0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check_outs("reset", 12'h000, 4'b0000, 3'd0);

        foreach (tbl[i])
            apply($sformatf("vec%0d", i), tbl[i]);

        // Single-step on ch3, len 3, steps at cycles 4, 9, 12: DRAIN@13, DONE@14, IDLE@15.
        for (int cyc = 0; cyc <= 14; cyc++) begin
            int e;
            logic [2:0] s;
            e = cyc + 1;
            drive(2'd2, (cyc == 0) ? 4'b1000 : 4'b0000, 4'b0,
                  (cyc == 4 || cyc == 9 || cyc == 12) ? 4'b1000 : 4'b0000,
                  (cyc == 14) ? 4'b1000 : 4'b0000, lens(3,0,0,0));
            tick();
            s = (e == 1) ? A : (e <= 12) ? R : (e == 13) ? D : (e == 14) ? O : I;
            check_outs($sformatf("step%0d", e), st4(s, I, I, I),
                       (e == 14) ? 4'b1000 : 4'b0000, (e <= 14) ? 3'd1 : 3'd0);
        end

        // Async reset mid-run: all four channels in RUN, reset lands between edges.
        apply("ar0", mk(2'd0, 4'b1111, 4'b0, 4'b0, 4'b0, lens(8,8,8,8), st4(A,A,A,A), 4'b0000, 3'd4));
        apply("ar1", mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(8,8,8,8), st4(R,R,R,R), 4'b0000, 3'd4));
        apply("ar2", mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(8,8,8,8), st4(R,R,R,R), 4'b0000, 3'd4));
        #3 rst_n = 1'b0;
        #1 check_outs("ar_async", 12'h000, 4'b0000, 3'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply("ar_idle0", mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(8,8,8,8), st4(I,I,I,I), 4'b0000, 3'd0));
        apply("ar_idle1", mk(2'd0, 4'b0000, 4'b0, 4'b0, 4'b0, lens(8,8,8,8), st4(I,I,I,I), 4'b0000, 3'd0));
        apply("ar_fresh", mk(2'd0, 4'b0001, 4'b0, 4'b0, 4'b0, lens(8,8,8,8), st4(I,I,I,A), 4'b0000, 3'd1));
        apply("ar_clear", mk(2'd0, 4'b0000, 4'b0001, 4'b0, 4'b0, lens(8,8,8,8), st4(I,I,I,I), 4'b0000, 3'd0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enum_chan_sequencer.md
Name: enum_chan_sequencer

Overview:
- Parametrised multi-channel phase sequencer.
- Each channel runs an independent FSM through packaged, explicitly-encoded enum states: IDLE/ARM/RUN/DRAIN/DONE.
- Run length is programmable per channel. Completion uses a done/ready handshake.
- Shared mode input selects one-shot, loop or single-step operation. Sits beside the datapath as a generic timing controller; state codes are exported for debug and other blocks.

Parameters:
- NCH, 4, number of independent channels (1..16).
- LEN_W, 8, width of per-channel run-length field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode_i  in  2  seq_mode_e, shared by all channels; sampled each cycle.
- start_i  in  NCH  per-channel start request (level sampled).
- abort_i  in  NCH  per-channel abort.
- step_i  in  NCH  per-channel advance enable, used in MODE_STEP only.
- len_i  in  NCH*LEN_W  per-channel run length; channel c at [c*LEN_W +: LEN_W].
- ready_i  in  NCH  per-channel completion acknowledge.
- state_o  out  NCH*3  per-channel seq_state_e; channel c at [c*3 +: 3].
- done_o  out  NCH  high while channel is in ST_DONE.
- busy_cnt_o  out  $clog2(NCH+1)  number of channels not in ST_IDLE.

Behaviour:
- Reset (rst_n low, async): all channels ST_IDLE, counters 0, done_o 0, busy_cnt_o 0, state_o all 3'b000. Reset mid-operation discards all progress; no done is issued.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Per-channel FSM, evaluated on clk rising edge:
  - ST_IDLE (3'b000): start_i=1 -> ST_ARM. Otherwise stay.
  - ST_ARM (3'b001): load cnt <= len_i. len_i==0 -> ST_DONE (skips RUN/DRAIN). Otherwise -> ST_RUN.
  - ST_RUN (3'b011): an enabled cycle is any cycle in MODE_ONESHOT/MODE_LOOP, or a cycle with step_i=1 in MODE_STEP. Each enabled cycle decrements cnt. If cnt==1 on an enabled cycle -> ST_DRAIN. RUN therefore lasts exactly L enabled cycles.
  - ST_DRAIN (3'b010): one cycle -> ST_DONE.
  - ST_DONE (3'b110): done_o=1, held until ready_i=1. On ready_i=1: MODE_LOOP -> ST_ARM (reloads current len_i); otherwise -> ST_IDLE.
- Latency in free-run mode with L>=1: start sampled at edge N gives ARM at N+1, RUN N+2..N+L+1, DRAIN N+L+2, DONE from N+L+3. With L=0: DONE at N+2.
- Priority: abort_i > all transitions. abort_i=1 forces ST_IDLE next edge from any state, including simultaneous start_i.
- start_i outside ST_IDLE is ignored. A held start_i in IDLE after a one-shot completes restarts the channel.
- len_i changes after ARM do not affect a run in progress.
- mode_i change mid-run takes effect on the next cycle. Switching to MODE_STEP freezes RUN until step_i.
- mode_i value 2'b11 is treated as MODE_ONESHOT.
- busy_cnt_o: registered popcount of next-state != ST_IDLE, so it aligns with state_o.
- Channels never interact; simultaneous events on different channels are independent.

Decomposition:
- Package seq_pkg:
  - typedef enum logic[2:0] seq_state_e {ST_IDLE=3'b000, ST_ARM=3'b001, ST_RUN=3'b011, ST_DRAIN=3'b010, ST_DONE=3'b110}. Codes are fixed and Gray-adjacent along the main path.
  - typedef enum logic[1:0] seq_mode_e {MODE_ONESHOT=2'b00, MODE_LOOP=2'b01, MODE_STEP=2'b10}.
  - Constant SEQ_STATE_W=3.
- Sub-module enum_seq_chan: one channel FSM plus counter, parametrised by LEN_W. The top generates NCH instances and the popcount register; it imports seq_pkg::* and refers to types both imported and as seq_pkg::seq_state_e.

Test Plan:
- Reset/one-shot: reset, NCH=4, mode=ONESHOT, len0=3, start0 pulse at cycle 0 -> state0 ARM@1, RUN@2-4, DRAIN@5, DONE@6. Hold ready0=0 to cycle 10: done0 stays 1. ready0=1@10 -> IDLE@11. busy_cnt_o is 1 throughout, 0 after.
- Zero length: len1=0, start1 -> ARM then DONE two cycles after start; RUN/DRAIN codes never appear.
- Loop: mode=LOOP, len2=2, ready2 tied 1 -> repeating ARM,RUN,RUN,DRAIN,DONE with period 5. Change len2 to 4 mid-RUN -> current run keeps 2, next ARM loads 4.
- Step: mode=STEP, len3=3, step3 pulsed on cycles 4, 9, 12 -> RUN leaves only after the third step, DRAIN@13.
- Abort/simultaneous: abort0 and start0 together in IDLE -> stays IDLE. abort0 during RUN -> IDLE next cycle, done0 never asserts, busy_cnt_o decrements.
- Async reset mid-run: drop rst_n between edges with all channels in RUN -> outputs go to 0 immediately, not waiting for an edge; after release, channels require a fresh start.
